// File: rtl/sprite_pkg.sv
// Shared sprite definitions: canvas/table defaults, table entry layout and scheduler states.
package sprite_pkg;

  localparam int DEFAULT_MAX_SPRITES = 32;
  localparam int DEFAULT_WIDTH       = 1280;
  localparam int DEFAULT_HEIGHT      = 720;
  localparam int DEFAULT_NUM_FRAMES  = 512;

  localparam int IDX_W   = $clog2(DEFAULT_MAX_SPRITES);
  localparam int X_W     = $clog2(DEFAULT_WIDTH);
  localparam int Y_W     = $clog2(DEFAULT_HEIGHT);
  localparam int FRAME_W = $clog2(DEFAULT_NUM_FRAMES);

  typedef struct packed {
    logic               active;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [FRAME_W-1:0] frame;
  } sprite_entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_RDY,
    S_OFFER,
    S_HOLDOFF,
    S_DONE
  } sched_state_t;

endpackage

// File: rtl/sprite_scheduler_if.sv
// Table write bus from game logic plus the sprite offer port towards graphics.
interface sprite_scheduler_if #(
  parameter int IW = sprite_pkg::IDX_W,
  parameter int XW = sprite_pkg::X_W,
  parameter int YW = sprite_pkg::Y_W,
  parameter int FW = sprite_pkg::FRAME_W
);
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic          wr_active;
  logic [XW-1:0] wr_x;
  logic [YW-1:0] wr_y;
  logic [FW-1:0] wr_frame;

  logic          sprite_ready;
  logic          sprite_valid;
  logic [XW-1:0] sprite_x;
  logic [YW-1:0] sprite_y;
  logic [FW-1:0] sprite_frame_number;

  modport master (
    output wr_en, wr_idx, wr_active, wr_x, wr_y, wr_frame, sprite_ready,
    input  sprite_valid, sprite_x, sprite_y, sprite_frame_number
  );

  modport slave (
    input  wr_en, wr_idx, wr_active, wr_x, wr_y, wr_frame, sprite_ready,
    output sprite_valid, sprite_x, sprite_y, sprite_frame_number
  );
endinterface

// File: rtl/sprite_table.sv
// Sprite register file: one write port, one registered read-first read port.
module sprite_table #(
  parameter int  MAX_SPRITES = sprite_pkg::DEFAULT_MAX_SPRITES,
  localparam int IW          = $clog2(MAX_SPRITES)
) (
  input  logic                     clk_pixel,
  input  logic                     sys_rst_n,
  input  logic                     wr_en,
  input  logic [IW-1:0]            wr_idx,
  input  sprite_pkg::sprite_entry_t wr_data,
  input  logic [IW-1:0]            rd_idx,
  output sprite_pkg::sprite_entry_t rd_data
);
  import sprite_pkg::*;

  logic [MAX_SPRITES-1:0]         active_q;
  logic [X_W+Y_W+FRAME_W-1:0]     payload_q [MAX_SPRITES];
  logic                           wr_hit;

  assign wr_hit = wr_en && ({1'b0, wr_idx} < (IW+1)'(MAX_SPRITES));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      active_q <= '0;
    end else if (wr_hit) begin
      active_q[wr_idx] <= wr_data.active;
    end
  end

  // NOTE: only the active bits are reset; coordinates of an inactive entry are never looked at.
  always_ff @(posedge clk_pixel) begin
    if (wr_hit) begin
      payload_q[wr_idx] <= {wr_data.x, wr_data.y, wr_data.frame};
    end
  end

  always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= {active_q[rd_idx], payload_q[rd_idx]};
    end
  end

endmodule

// File: rtl/sprite_scheduler.sv
// Per-frame scan of the sprite table feeding active entries to graphics in index order.
// Optional SPRITE_SCHED_STATS_EN adds overrun_count and sprites_last status outputs.
module sprite_scheduler #(
  parameter int MAX_SPRITES = sprite_pkg::DEFAULT_MAX_SPRITES,
  parameter int WIDTH       = sprite_pkg::DEFAULT_WIDTH,
  parameter int HEIGHT      = sprite_pkg::DEFAULT_HEIGHT,
  parameter int NUM_FRAMES  = sprite_pkg::DEFAULT_NUM_FRAMES
) (
  input  logic              clk_pixel,
  input  logic              sys_rst_n,
  input  logic [5:0]        frame_count,
  sprite_scheduler_if.slave bus,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
`ifdef SPRITE_SCHED_STATS_EN
  ,
  output logic [15:0]                    overrun_count,
  output logic [$clog2(MAX_SPRITES):0]   sprites_last
`endif
);
  import sprite_pkg::*;

  localparam int IW = $clog2(MAX_SPRITES);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int FW = $clog2(NUM_FRAMES);
  localparam logic [IW-1:0] LAST_IDX = IW'(MAX_SPRITES - 1);

  sched_state_t  state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          restart_q, restart_d;
  logic          load_fields;
  logic [5:0]    prev_fc_q;
  logic          primed_q;
  logic          frame_start;
  logic          overrun_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [FW-1:0] frame_q;
  sprite_entry_t wr_entry, rd_entry;

  assign wr_entry = '{active: bus.wr_active, x: bus.wr_x, y: bus.wr_y, frame: bus.wr_frame};

  // Read address is the next index so the entry is ready the cycle FETCH looks at it.
  sprite_table #(.MAX_SPRITES(MAX_SPRITES)) u_table (
    .clk_pixel (clk_pixel),
    .sys_rst_n (sys_rst_n),
    .wr_en     (bus.wr_en),
    .wr_idx    (bus.wr_idx),
    .wr_data   (wr_entry),
    .rd_idx    (idx_d),
    .rd_data   (rd_entry)
  );

  // primed_q keeps the first post-reset cycle from looking like a frame change.
  always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      prev_fc_q <= '0;
      primed_q  <= 1'b0;
    end else begin
      prev_fc_q <= frame_count;
      primed_q  <= 1'b1;
    end
  end

  assign frame_start = primed_q && (frame_count != prev_fc_q);
  assign busy        = state_q inside {S_FETCH, S_WAIT_RDY, S_OFFER, S_HOLDOFF};

  always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      restart_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      restart_q <= restart_d;
      overrun_q <= frame_start && busy;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    restart_d   = restart_q;
    load_fields = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (frame_start) begin
          state_d = S_FETCH;
          idx_d   = '0;
        end
      end
      S_FETCH: begin
        if (frame_start) begin
          idx_d = '0;
        end else if (rd_entry.active) begin
          load_fields = 1'b1;
          state_d     = S_WAIT_RDY;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_WAIT_RDY: begin
        if (frame_start) begin
          state_d = S_FETCH;
          idx_d   = '0;
        end else if (bus.sprite_ready) begin
          state_d = S_OFFER;
        end
      end
      S_OFFER: begin
        state_d = S_HOLDOFF;
        if (frame_start) restart_d = 1'b1;
      end
      S_HOLDOFF: begin
        restart_d = 1'b0;
        if (frame_start || restart_q) begin
          state_d = S_FETCH;
          idx_d   = '0;
        end else if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FETCH;
          idx_d   = idx_q + IW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= '0;
    end else if (load_fields) begin
      x_q     <= rd_entry.x;
      y_q     <= rd_entry.y;
      frame_q <= rd_entry.frame;
    end
  end

  assign bus.sprite_valid        = (state_q == S_OFFER);
  assign bus.sprite_x            = x_q;
  assign bus.sprite_y            = y_q;
  assign bus.sprite_frame_number = frame_q;
  assign frame_done              = (state_q == S_DONE);
  assign overrun                 = overrun_q;

`ifdef SPRITE_SCHED_STATS_EN
  logic [IW:0] accepted_q;

  always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      overrun_count <= '0;
      sprites_last  <= '0;
      accepted_q    <= '0;
    end else begin
      if (frame_start && busy && overrun_count != '1) overrun_count <= overrun_count + 16'd1;
      if (state_q == S_DONE) sprites_last <= accepted_q;
      if ((frame_start && state_q != S_OFFER) || (state_q == S_HOLDOFF && restart_q)) begin
        accepted_q <= '0;
      end else if (state_q == S_OFFER) begin
        accepted_q <= accepted_q + (IW+1)'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_sprite_scheduler.sv
// Scoreboard bench for sprite_scheduler: a table model snapshots active entries at each frame
// start; a monitor pops and compares every offered sprite and checks frame_done drains the queue.
module tb_sprite_scheduler;
  import sprite_pkg::*;

  localparam int N        = DEFAULT_MAX_SPRITES;
  localparam int DONE_LAT = N + 1;
  localparam int RDY_LOW = 0, RDY_HIGH = 1, RDY_RANDOM = 2, RDY_SLOW = 3;

  typedef logic [X_W+Y_W+FRAME_W-1:0] rec_t;

  logic       clk_pixel = 1'b0;
  logic       sys_rst_n;
  logic [5:0] frame_count;
  logic       busy, frame_done, overrun;
`ifdef SPRITE_SCHED_STATS_EN
  logic [15:0]     overrun_count;
  logic [IDX_W:0]  sprites_last;
`endif

  sprite_scheduler_if bus ();

  sprite_scheduler dut (
    .clk_pixel   (clk_pixel),
    .sys_rst_n   (sys_rst_n),
    .frame_count (frame_count),
    .bus         (bus),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun)
`ifdef SPRITE_SCHED_STATS_EN
    ,
    .overrun_count (overrun_count),
    .sprites_last  (sprites_last)
`endif
  );

  always #5 clk_pixel = ~clk_pixel;

  // Reference model of the table and the expected offers of the scan in flight.
  bit               m_act [N];
  logic [X_W-1:0]   m_x   [N];
  logic [Y_W-1:0]   m_y   [N];
  logic [FRAME_W-1:0] m_f [N];
  rec_t             exp_q [$];

  int checks, errors;
  int done_seen, valid_seen, overrun_seen, exp_done, exp_overrun;
  int rdy_mode, slow_cnt;
  bit prev_valid;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic write_entry(input int idx, input bit act, input int unsigned x,
                             input int unsigned y, input int unsigned f);
    bus.wr_en     = 1'b1;
    bus.wr_idx    = IDX_W'(idx);
    bus.wr_active = act;
    bus.wr_x      = X_W'(x);
    bus.wr_y      = Y_W'(y);
    bus.wr_frame  = FRAME_W'(f);
    m_act[idx] = act;
    m_x[idx]   = X_W'(x);
    m_y[idx]   = Y_W'(y);
    m_f[idx]   = FRAME_W'(f);
    @(negedge clk_pixel);
    bus.wr_en = 1'b0;
  endtask

  // A restart replaces the scan in flight, so it adds an overrun but no extra frame_done.
  task automatic step_frame(input bit restart);
    frame_count = frame_count + 6'd1;
    if (restart) begin
      exp_q.delete();
      exp_overrun++;
    end else begin
      exp_done++;
    end
    for (int i = 0; i < N; i++)
      if (m_act[i]) exp_q.push_back({m_x[i], m_y[i], m_f[i]});
  endtask

  task automatic wait_offer(input int want_x, input int budget);
    bit found = 1'b0;
    int k = 0;
    while (!found && k < budget) begin
      @(negedge clk_pixel);
      k++;
      if (bus.sprite_valid === 1'b1 && (want_x < 0 || int'(bus.sprite_x) == want_x)) found = 1'b1;
    end
    check(found, "offer_seen", found, 1);
  endtask

  task automatic wait_done(input int budget);
    bit found = 1'b0;
    int k = 0;
    while (!found && k < budget) begin
      @(negedge clk_pixel);
      k++;
      if (frame_done === 1'b1) found = 1'b1;
    end
    check(found, "frame_done_seen", found, 1);
  endtask

  task automatic empty_frame_timing();
    bit found = 1'b0;
    int n = 0;
    step_frame(1'b0);
    while (!found && n < 3 * N) begin
      @(negedge clk_pixel);
      n++;
      if (frame_done === 1'b1) found = 1'b1;
    end
    check(found && n == DONE_LAT, "empty_done_latency", n, DONE_LAT);
  endtask

  // Monitor: every offer must be single-cycle and match the head of the scoreboard.
  always @(negedge clk_pixel) begin
    rec_t got, e;
    if (!sys_rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.sprite_valid === 1'b1) begin
        valid_seen++;
        check(!prev_valid, "valid_one_cycle", prev_valid, 0);
        check(exp_q.size() != 0, "offer_expected", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
          e   = exp_q.pop_front();
          got = {bus.sprite_x, bus.sprite_y, bus.sprite_frame_number};
          check(got === e, "offer_fields", got, e);
        end
      end
      if (frame_done === 1'b1) begin
        done_seen++;
        check(exp_q.size() == 0, "done_after_all_offers", exp_q.size(), 0);
      end
      if (overrun === 1'b1) overrun_seen++;
      prev_valid = (bus.sprite_valid === 1'b1);
    end
  end

  initial begin
    bus.sprite_ready = 1'b0;
    slow_cnt = 0;
    forever begin
      @(negedge clk_pixel);
      case (rdy_mode)
        RDY_HIGH:   bus.sprite_ready = 1'b1;
        RDY_RANDOM: bus.sprite_ready = ($urandom_range(0, 3) != 0);
        RDY_SLOW: begin
          if (bus.sprite_valid === 1'b1) slow_cnt = 0;
          else if (slow_cnt < 40) slow_cnt++;
          bus.sprite_ready = (slow_cnt >= 40);
        end
        default:    bus.sprite_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    sys_rst_n = 1'b0;
    frame_count = '0;
    bus.wr_en = 1'b0;
    bus.wr_idx = '0;
    bus.wr_active = 1'b0;
    bus.wr_x = '0;
    bus.wr_y = '0;
    bus.wr_frame = '0;
    rdy_mode = RDY_LOW;
    for (int i = 0; i < N; i++) begin
      m_act[i] = 1'b0; m_x[i] = '0; m_y[i] = '0; m_f[i] = '0;
    end

    repeat (3) @(negedge clk_pixel);
    check(bus.sprite_valid === 1'b0, "reset_valid", bus.sprite_valid, 0);
    check(busy === 1'b0, "reset_busy", busy, 0);
    check(frame_done === 1'b0, "reset_frame_done", frame_done, 0);
    check(overrun === 1'b0, "reset_overrun", overrun, 0);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge clk_pixel);
    check(busy === 1'b0, "idle_after_reset", busy, 0);

    // Empty table: no offers, frame_done exactly MAX_SPRITES+1 cycles after the frame edge.
    empty_frame_timing();

    // Entries 0, 3, 7 with graphics always ready.
    write_entry(0, 1'b1, 10, 20, 5);
    write_entry(3, 1'b1, 100, 200, 9);
    write_entry(7, 1'b1, 1200, 700, 511);
    rdy_mode = RDY_HIGH;
    @(negedge clk_pixel);
    cnt = valid_seen;
    step_frame(1'b0);
    wait_done(200);
    repeat (3) @(negedge clk_pixel);
    check(valid_seen - cnt == 3, "three_offers", valid_seen - cnt, 3);

    // Ready withheld for 50 cycles after the first accept.
    step_frame(1'b0);
    wait_offer(-1, 100);
    rdy_mode = RDY_LOW;
    bus.sprite_ready = 1'b0;
    cnt = 0;
    repeat (50) begin
      @(negedge clk_pixel);
      if (bus.sprite_valid === 1'b1) cnt++;
    end
    check(cnt == 0, "no_offer_without_ready", cnt, 0);
    check(busy === 1'b1, "busy_while_stalled", busy, 1);
    rdy_mode = RDY_HIGH;
    wait_done(200);

    // Rewrite entry 3 while it is being offered: old values now, new values next frame.
    @(negedge clk_pixel);
    step_frame(1'b0);
    wait_offer(100, 200);
    write_entry(3, 1'b1, 5, 5, 2);
    wait_done(200);
    @(negedge clk_pixel);
    step_frame(1'b0);
    wait_done(200);

    // Full table, slow graphics, frame edge mid-scan.
    for (int i = 0; i < N; i++)
      write_entry(i, 1'b1, $urandom, $urandom, $urandom);
    slow_cnt = 0;
    rdy_mode = RDY_SLOW;
    @(negedge clk_pixel);
    step_frame(1'b0);
    repeat (3) wait_offer(-1, 100);
    repeat (20) @(negedge clk_pixel);
    check(busy === 1'b1, "busy_before_overrun", busy, 1);
    step_frame(1'b1);
    @(negedge clk_pixel);
    check(overrun === 1'b1, "overrun_pulse", overrun, 1);
    @(negedge clk_pixel);
    check(overrun === 1'b0, "overrun_one_cycle", overrun, 0);
    wait_done(2000);
`ifdef SPRITE_SCHED_STATS_EN
    check(overrun_count == 16'd1, "overrun_count", overrun_count, 1);
`endif

    // Randomized table updates and ready patterns.
    rdy_mode = RDY_RANDOM;
    repeat (4) begin
      repeat (8) write_entry(int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)),
                             $urandom, $urandom, $urandom);
      @(negedge clk_pixel);
      step_frame(1'b0);
      wait_done(1000);
    end

    // Reset during an offer: valid drops at once and the table comes back empty.
    write_entry(0, 1'b1, 33, 44, 55);
    rdy_mode = RDY_HIGH;
    @(negedge clk_pixel);
    step_frame(1'b0);
    wait_offer(-1, 200);
    #2;
    sys_rst_n = 1'b0;
    exp_q.delete();
    exp_done--;
    for (int i = 0; i < N; i++) m_act[i] = 1'b0;
    #1;
    check(bus.sprite_valid === 1'b0, "reset_kills_valid", bus.sprite_valid, 0);
    check(busy === 1'b0, "reset_kills_busy", busy, 0);
    repeat (2) @(negedge clk_pixel);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge clk_pixel);
    empty_frame_timing();

    repeat (3) @(negedge clk_pixel);
    check(done_seen == exp_done, "frame_done_count", done_seen, exp_done);
    check(overrun_seen == exp_overrun, "overrun_count_seen", overrun_seen, exp_overrun);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
